// File: rtl/y86_pkg.sv
// Shared Y86 pipeline definitions: icodes, status encodings, register IDs and the W payload.
package y86_pkg;

    localparam int unsigned ICODE_W = 4;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned VAL_W   = 64;

    localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

    localparam logic [1:0] S_AOK = 2'd0;
    localparam logic [1:0] S_HLT = 2'd1;
    localparam logic [1:0] S_ADR = 2'd2;
    localparam logic [1:0] S_INS = 2'd3;

    localparam logic [REG_W-1:0]   RNONE     = 4'hF;
    localparam logic [REG_W-1:0]   RRSP      = 4'h4;
    localparam logic [ICODE_W-1:0] NOP_ICODE = I_NOP;

    typedef struct packed {
        logic [ICODE_W-1:0] icode;
        logic               cond;
        logic [REG_W-1:0]   reg_a;
        logic [REG_W-1:0]   reg_b;
        logic [VAL_W-1:0]   val_e;
        logic [VAL_W-1:0]   val_m;
    } w_reg_t;

    localparam w_reg_t W_BUBBLE = '{icode: NOP_ICODE, cond: 1'b0, reg_a: RNONE,
                                    reg_b: RNONE, val_e: '0, val_m: '0};

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage to write-back bus; retire_count exists only with WB_RETIRE_COUNT_EN.
interface wb_stage_if #(parameter int unsigned STAT_W = 2);

    logic [STAT_W-1:0] m_stat;
    logic [3:0]        m_icode;
    logic              m_cond;
    logic [3:0]        m_regA;
    logic [3:0]        m_regB;
    logic [63:0]       m_valE;
    logic [63:0]       m_valM;
    logic              w_stall;
    logic              w_bubble;
    logic [3:0]        w_icode;
    logic              w_cond;
    logic [3:0]        w_regA;
    logic [3:0]        w_regB;
    logic [63:0]       w_valE;
    logic [63:0]       w_valM;
    logic [3:0]        w_dstE;
    logic [3:0]        w_dstM;
    logic [STAT_W-1:0] w_stat;
    logic              halted;
`ifdef WB_RETIRE_COUNT_EN
    logic [63:0]       retire_count;
`endif

    modport master (
        output m_stat, m_icode, m_cond, m_regA, m_regB, m_valE, m_valM, w_stall, w_bubble,
        input  w_icode, w_cond, w_regA, w_regB, w_valE, w_valM, w_dstE, w_dstM, w_stat, halted
`ifdef WB_RETIRE_COUNT_EN
        , input retire_count
`endif
    );

    modport slave (
        input  m_stat, m_icode, m_cond, m_regA, m_regB, m_valE, m_valM, w_stall, w_bubble,
        output w_icode, w_cond, w_regA, w_regB, w_valE, w_valM, w_dstE, w_dstM, w_stat, halted
`ifdef WB_RETIRE_COUNT_EN
        , output retire_count
`endif
    );

endinterface

// File: rtl/wb_dst_decode.sv
// Effective destination register IDs of an instruction; shared with the forwarding unit.
module wb_dst_decode
    import y86_pkg::*;
(
    input  logic [ICODE_W-1:0] icode,
    input  logic               cond,
    input  logic [REG_W-1:0]   reg_a,
    input  logic [REG_W-1:0]   reg_b,
    input  logic               stat_ok,
    output logic [REG_W-1:0]   dst_e_c,
    output logic [REG_W-1:0]   dst_m_c
);

    always_comb begin
        dst_e_c = RNONE;
        dst_m_c = RNONE;
        if (stat_ok) begin
            case (icode)
                I_RRMOVQ:                        if (cond) dst_e_c = reg_b;
                I_IRMOVQ, I_OPQ:                 dst_e_c = reg_b;
                I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e_c = RRSP;
                default:                         dst_e_c = RNONE;
            endcase
            if (icode == I_MRMOVQ || icode == I_POPQ) dst_m_c = reg_a;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Y86 write-back stage: W pipeline register, write masking, sticky halt.
// Optional WB_RETIRE_COUNT_EN adds a retired-instruction counter.
module wb_stage
    import y86_pkg::*;
#(
    parameter int unsigned STAT_W = 2
)
(
    input  logic       clock,
    input  logic       reset,
    wb_stage_if.slave  wb
);

    w_reg_t            w_q;
    logic [STAT_W-1:0] stat_q;
    logic              halted_q;
    logic              stat_ok_c;
    logic              m_ok_c;
    logic [REG_W-1:0]  dst_e_c;
    logic [REG_W-1:0]  dst_m_c;

    assign stat_ok_c = (stat_q == STAT_W'(S_AOK));
    assign m_ok_c    = (wb.m_stat == STAT_W'(S_AOK));

    // Once halted the register freezes regardless of stall/bubble until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_q      <= W_BUBBLE;
            stat_q   <= STAT_W'(S_AOK);
            halted_q <= 1'b0;
        end else if (!halted_q && !wb.w_stall) begin
            if (wb.w_bubble) begin
                w_q    <= W_BUBBLE;
                stat_q <= STAT_W'(S_AOK);
            end else begin
                w_q      <= '{icode: wb.m_icode, cond: wb.m_cond, reg_a: wb.m_regA,
                              reg_b: wb.m_regB, val_e: wb.m_valE, val_m: wb.m_valM};
                stat_q   <= wb.m_stat;
                halted_q <= !m_ok_c;
            end
        end
    end

    wb_dst_decode u_dst_decode (
        .icode   (w_q.icode),
        .cond    (w_q.cond),
        .reg_a   (w_q.reg_a),
        .reg_b   (w_q.reg_b),
        .stat_ok (stat_ok_c),
        .dst_e_c (dst_e_c),
        .dst_m_c (dst_m_c)
    );

    // A faulting instruction shows as NOP so it never touches architectural state.
    assign wb.w_icode = stat_ok_c ? w_q.icode : NOP_ICODE;
    assign wb.w_cond  = w_q.cond;
    assign wb.w_regA  = w_q.reg_a;
    assign wb.w_regB  = w_q.reg_b;
    assign wb.w_valE  = w_q.val_e;
    assign wb.w_valM  = w_q.val_m;
    assign wb.w_dstE  = dst_e_c;
    assign wb.w_dstM  = dst_m_c;
    assign wb.w_stat  = stat_q;
    assign wb.halted  = halted_q;

`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] retire_q;
    logic        load_c;

    assign load_c = !halted_q && !wb.w_stall && !wb.w_bubble;

    always_ff @(posedge clock) begin
        if (reset) begin
            retire_q <= '0;
        end else if (load_c && m_ok_c) begin
            retire_q <= retire_q + 64'd1;
        end
    end

    assign wb.retire_count = retire_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a falling-edge register file model on the write side.
module tb_wb_stage;
    import y86_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    logic [63:0] rf [16];

    wb_stage_if #(.STAT_W(2)) bus ();

    wb_stage #(.STAT_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .wb    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Register file commits at the falling edge; the later M write wins over E.
    always @(negedge clock) begin
        if (bus.w_dstE != 4'hF) rf[bus.w_dstE] <= bus.w_valE;
        if (bus.w_dstM != 4'hF) rf[bus.w_dstM] <= bus.w_valM;
    end

    task automatic drive(input logic [1:0] st, input logic [3:0] ic, input logic cd,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] ve, input logic [63:0] vm);
        bus.m_stat  = st;
        bus.m_icode = ic;
        bus.m_cond  = cd;
        bus.m_regA  = ra;
        bus.m_regB  = rb;
        bus.m_valE  = ve;
        bus.m_valM  = vm;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.w_stall = 1'b0;
        bus.w_bubble = 1'b0;
        drive(S_ADR, I_OPQ, 1'b1, 4'h3, 4'h5, 64'hDEAD, 64'hBEEF);
        step();
        step();
        checks++; if (bus.w_icode !== 4'h1) begin failures++; $display("FAIL reset_icode got=%h exp=1", bus.w_icode); end
        checks++; if (bus.w_stat !== 2'd0) begin failures++; $display("FAIL reset_stat got=%h exp=0", bus.w_stat); end
        checks++; if (bus.w_cond !== 1'b0) begin failures++; $display("FAIL reset_cond got=%h exp=0", bus.w_cond); end
        checks++; if (bus.w_regA !== 4'hF || bus.w_regB !== 4'hF) begin failures++; $display("FAIL reset_regs got=%h/%h exp=f/f", bus.w_regA, bus.w_regB); end
        checks++; if (bus.w_valE !== 64'd0 || bus.w_valM !== 64'd0) begin failures++; $display("FAIL reset_vals got=%h/%h exp=0/0", bus.w_valE, bus.w_valM); end
        checks++; if (bus.w_dstE !== 4'hF || bus.w_dstM !== 4'hF) begin failures++; $display("FAIL reset_dsts got=%h/%h exp=f/f", bus.w_dstE, bus.w_dstM); end
        checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
`ifdef WB_RETIRE_COUNT_EN
        checks++; if (bus.retire_count !== 64'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.retire_count); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_irmovq();
        drive(S_AOK, I_IRMOVQ, 1'b0, 4'hF, 4'h2, 64'h55, 64'h0);
        step();
        checks++; if (bus.w_icode !== 4'h3) begin failures++; $display("FAIL irmovq_icode got=%h exp=3", bus.w_icode); end
        checks++; if (bus.w_dstE !== 4'h2) begin failures++; $display("FAIL irmovq_dstE got=%h exp=2", bus.w_dstE); end
        checks++; if (bus.w_dstM !== 4'hF) begin failures++; $display("FAIL irmovq_dstM got=%h exp=f", bus.w_dstM); end
        @(negedge clock); #1;
        checks++; if (rf[2] !== 64'h55) begin failures++; $display("FAIL irmovq_rdx got=%h exp=55", rf[2]); end
    endtask

    task automatic test_cmov();
        drive(S_AOK, I_RRMOVQ, 1'b0, 4'h1, 4'h3, 64'h99, 64'h0);
        step();
        checks++; if (bus.w_dstE !== 4'hF) begin failures++; $display("FAIL cmov_nt_dstE got=%h exp=f", bus.w_dstE); end
        @(negedge clock); #1;
        checks++; if (rf[3] !== 64'h0) begin failures++; $display("FAIL cmov_nt_rbx got=%h exp=0", rf[3]); end
        drive(S_AOK, I_RRMOVQ, 1'b1, 4'h1, 4'h3, 64'h99, 64'h0);
        step();
        checks++; if (bus.w_dstE !== 4'h3) begin failures++; $display("FAIL cmov_t_dstE got=%h exp=3", bus.w_dstE); end
        @(negedge clock); #1;
        checks++; if (rf[3] !== 64'h99) begin failures++; $display("FAIL cmov_t_rbx got=%h exp=99", rf[3]); end
    endtask

    task automatic test_popq();
        drive(S_AOK, I_POPQ, 1'b0, 4'h4, 4'hF, 64'd1008, 64'h77);
        step();
        checks++; if (bus.w_dstE !== 4'h4 || bus.w_dstM !== 4'h4) begin failures++; $display("FAIL popq_dsts got=%h/%h exp=4/4", bus.w_dstE, bus.w_dstM); end
        @(negedge clock); #1;
        checks++; if (rf[4] !== 64'h77) begin failures++; $display("FAIL popq_rsp got=%h exp=77", rf[4]); end
    endtask

    task automatic test_stall_bubble();
        drive(S_AOK, I_MRMOVQ, 1'b0, 4'h1, 4'hF, 64'h20, 64'h33);
        bus.w_stall = 1'b1;
        bus.w_bubble = 1'b1;
        step();
        checks++; if (bus.w_icode !== 4'hB || bus.w_valM !== 64'h77) begin failures++; $display("FAIL stallbub_hold got=%h/%h exp=b/77", bus.w_icode, bus.w_valM); end
        checks++; if (bus.w_dstM !== 4'h4) begin failures++; $display("FAIL stallbub_dstM got=%h exp=4", bus.w_dstM); end
        bus.w_stall = 1'b0;
        step();
        checks++; if (bus.w_icode !== 4'h1 || bus.w_regA !== 4'hF || bus.w_valE !== 64'd0) begin failures++; $display("FAIL bubble_fields got=%h/%h/%h exp=1/f/0", bus.w_icode, bus.w_regA, bus.w_valE); end
        checks++; if (bus.w_dstE !== 4'hF || bus.w_dstM !== 4'hF) begin failures++; $display("FAIL bubble_dsts got=%h/%h exp=f/f", bus.w_dstE, bus.w_dstM); end
        bus.w_bubble = 1'b0;
        step();
        checks++; if (bus.w_icode !== 4'h5 || bus.w_dstM !== 4'h1 || bus.w_dstE !== 4'hF) begin failures++; $display("FAIL mrmovq_load got=%h/%h/%h exp=5/1/f", bus.w_icode, bus.w_dstM, bus.w_dstE); end
    endtask

    task automatic test_dst_map();
        logic [3:0] ic [12];
        logic [3:0] exp_e [12];
        logic [3:0] exp_m [12];
        ic    = '{I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ};
        exp_e = '{4'hF, 4'hF, 4'h2, 4'h2, 4'hF, 4'hF, 4'h2, 4'hF, 4'h4, 4'h4, 4'h4, 4'h4};
        exp_m = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h1};
        for (int i = 0; i < 12; i++) begin
            drive(S_AOK, ic[i], 1'b1, 4'h1, 4'h2, 64'(i), 64'(i + 100));
            step();
            checks++;
            if (bus.w_dstE !== exp_e[i] || bus.w_dstM !== exp_m[i]) begin
                failures++;
                $display("FAIL dst_map icode=%h got=%h/%h exp=%h/%h", ic[i], bus.w_dstE, bus.w_dstM, exp_e[i], exp_m[i]);
            end
        end
    endtask

    task automatic test_halt();
        drive(S_ADR, I_MRMOVQ, 1'b0, 4'h1, 4'hF, 64'h40, 64'h0);
        step();
        checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL adr_halted got=%b exp=1", bus.halted); end
        checks++; if (bus.w_icode !== 4'h1 || bus.w_stat !== 2'd2) begin failures++; $display("FAIL adr_mask got=%h/%h exp=1/2", bus.w_icode, bus.w_stat); end
        checks++; if (bus.w_dstE !== 4'hF || bus.w_dstM !== 4'hF) begin failures++; $display("FAIL adr_dsts got=%h/%h exp=f/f", bus.w_dstE, bus.w_dstM); end
        for (int i = 0; i < 4; i++) begin
            drive(S_AOK, I_IRMOVQ, 1'b0, 4'hF, 4'h5, 64'(i + 1), 64'h0);
            bus.w_bubble = (i == 3);
            step();
            checks++;
            if (bus.w_stat !== 2'd2 || bus.w_valE !== 64'h40 || bus.w_regA !== 4'h1 || bus.halted !== 1'b1) begin
                failures++;
                $display("FAIL halt_frozen i=%0d got=%h/%h/%h/%b exp=2/40/1/1", i, bus.w_stat, bus.w_valE, bus.w_regA, bus.halted);
            end
        end
        bus.w_bubble = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus.halted !== 1'b0 || bus.w_stat !== 2'd0 || bus.w_icode !== 4'h1 || bus.w_valE !== 64'd0) begin failures++; $display("FAIL halt_reset got=%b/%h/%h/%h exp=0/0/1/0", bus.halted, bus.w_stat, bus.w_icode, bus.w_valE); end
    endtask

    task automatic test_stall_nonaok();
        bus.w_stall = 1'b1;
        drive(S_HLT, I_HALT, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
        step();
        checks++; if (bus.halted !== 1'b0 || bus.w_stat !== 2'd0) begin failures++; $display("FAIL stalled_hlt got=%b/%h exp=0/0", bus.halted, bus.w_stat); end
        bus.w_stall = 1'b0;
        step();
        checks++; if (bus.halted !== 1'b1 || bus.w_stat !== 2'd1 || bus.w_icode !== 4'h1) begin failures++; $display("FAIL hlt_load got=%b/%h/%h exp=1/1/1", bus.halted, bus.w_stat, bus.w_icode); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(S_INS, I_OPQ, 1'b0, 4'h1, 4'h2, 64'h5, 64'h0);
        step();
        checks++; if (bus.halted !== 1'b1 || bus.w_stat !== 2'd3 || bus.w_dstE !== 4'hF) begin failures++; $display("FAIL ins_load got=%b/%h/%h exp=1/3/f", bus.halted, bus.w_stat, bus.w_dstE); end
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

`ifdef WB_RETIRE_COUNT_EN
    task automatic test_retire_count();
        for (int i = 0; i < 8; i++) begin
            drive(S_AOK, I_IRMOVQ, 1'b0, 4'hF, 4'h6, 64'(i), 64'h0);
            bus.w_bubble = (i == 5);
            bus.w_stall  = (i >= 6);
            step();
        end
        bus.w_bubble = 1'b0;
        bus.w_stall  = 1'b0;
        checks++; if (bus.retire_count !== 64'd5) begin failures++; $display("FAIL retire_count got=%0d exp=5", bus.retire_count); end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 16; i++) rf[i] = 64'd0;
        test_reset();
        test_irmovq();
        test_cmov();
        test_popq();
        test_stall_bubble();
        test_dst_map();
        test_halt();
        test_stall_nonaok();
`ifdef WB_RETIRE_COUNT_EN
        test_retire_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
